// File: rtl/gcd_stein_unit.sv
// Binary (Stein) GCD engine: one shift or subtract step per clock, with a tag
// carried through and the ALIGN+ITER cycle count reported with the result.
module gcd_stein_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_gcd,
  output logic [TAG_W-1:0] o_tag,
  output logic [CNT_W-1:0] o_cycles,
  output logic             o_valid,
  input  logic             i_ready
);

  localparam int unsigned K_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ALIGN,
    S_ITER,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [K_W-1:0]   k;
  logic [CNT_W-1:0] cnt;
  logic [TAG_W-1:0] tag;
  logic [CNT_W-1:0] cnt_inc;

  // Iteration counter saturates rather than wrapping.
  always_comb begin
    cnt_inc = cnt;
    if (cnt != '1) cnt_inc = cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ra       <= '0;
      rb       <= '0;
      k        <= '0;
      cnt      <= '0;
      tag      <= '0;
      o_ready  <= 1'b1;
      o_valid  <= 1'b0;
      o_gcd    <= '0;
      o_tag    <= '0;
      o_cycles <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_valid && o_ready) begin
            ra      <= i_a;
            rb      <= i_b;
            tag     <= i_tag;
            k       <= '0;
            cnt     <= '0;
            o_ready <= 1'b0;
            if (i_a == '0 || i_b == '0) begin
              o_gcd    <= i_a | i_b;
              o_tag    <= i_tag;
              o_cycles <= '0;
              state    <= S_DONE;
            end else begin
              state <= S_ALIGN;
            end
          end
        end
        S_ALIGN: begin
          cnt <= cnt_inc;
          if (!ra[0] && !rb[0]) begin
            ra <= ra >> 1;
            rb <= rb >> 1;
            k  <= k + 1'b1;
          end else begin
            state <= S_ITER;
          end
        end
        S_ITER: begin
          cnt <= cnt_inc;
          if (!ra[0] || !rb[0]) begin
            if (!ra[0]) ra <= ra >> 1;
            if (!rb[0]) rb <= rb >> 1;
          end else if (ra == rb) begin
            o_gcd    <= ra << k;
            o_tag    <= tag;
            o_cycles <= cnt_inc;
            state    <= S_DONE;
          end else if (ra > rb) begin
            ra <= ra - rb;
          end else begin
            rb <= rb - ra;
          end
        end
        S_DONE: begin
          // o_valid rises one edge after entering DONE.
          if (!o_valid) begin
            o_valid <= 1'b1;
          end else if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_stein_unit.sv
// Bench for gcd_stein_unit: default 8-bit unit, 16-bit/8-bit-tag unit and an
// 8-bit unit with a 3-bit cycle counter to reach saturation.
module tb_gcd_stein_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  a0, b0, a2, b2;
  logic [15:0] a1, b1;
  logic [3:0]  t0, t2;
  logic [7:0]  t1;
  logic [2:0]  v, rdy, ov, dr;
  logic [7:0]  g0, g2;
  logic [15:0] g1;
  logic [3:0]  ot0, ot2;
  logic [7:0]  ot1;
  logic [7:0]  c0, c1;
  logic [2:0]  c2;

  gcd_stein_unit u0 (
    .clk(clk), .rst(rst), .i_a(a0), .i_b(b0), .i_tag(t0), .i_valid(v[0]),
    .o_ready(rdy[0]), .o_gcd(g0), .o_tag(ot0), .o_cycles(c0), .o_valid(ov[0]),
    .i_ready(dr[0])
  );

  gcd_stein_unit #(.WIDTH(16), .TAG_W(8), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .i_a(a1), .i_b(b1), .i_tag(t1), .i_valid(v[1]),
    .o_ready(rdy[1]), .o_gcd(g1), .o_tag(ot1), .o_cycles(c1), .o_valid(ov[1]),
    .i_ready(dr[1])
  );

  gcd_stein_unit #(.WIDTH(8), .TAG_W(4), .CNT_W(3)) u2 (
    .clk(clk), .rst(rst), .i_a(a2), .i_b(b2), .i_tag(t2), .i_valid(v[2]),
    .o_ready(rdy[2]), .o_gcd(g2), .o_tag(ot2), .o_cycles(c2), .o_valid(ov[2]),
    .i_ready(dr[2])
  );

  logic [15:0] gx[3];
  logic [7:0]  tx[3];
  logic [7:0]  cx[3];

  always_comb begin
    gx[0] = {8'h00, g0};
    gx[1] = g1;
    gx[2] = {8'h00, g2};
    tx[0] = {4'h0, ot0};
    tx[1] = ot1;
    tx[2] = {4'h0, ot2};
    cx[0] = c0;
    cx[1] = c1;
    cx[2] = {5'b0, c2};
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int s, input logic [15:0] a, input logic [15:0] b,
                       input logic [7:0] t);
    case (s)
      0: begin a0 = a[7:0]; b0 = b[7:0]; t0 = t[3:0]; end
      1: begin a1 = a;      b1 = b;      t1 = t;      end
      default: begin a2 = a[7:0]; b2 = b[7:0]; t2 = t[3:0]; end
    endcase
  endtask

  function automatic logic [15:0] ref_gcd(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x = a;
    logic [15:0] y = b;
    logic [15:0] r;
    while (y != 0) begin
      r = x % y;
      x = y;
      y = r;
    end
    return x;
  endfunction

  // Issues one request, then counts edges after the acceptance edge until
  // o_valid is seen. With keep set, i_valid stays high with junk operands.
  task automatic run_op(input int s, input logic [15:0] a, input logic [15:0] b,
                        input logic [7:0] t, input bit keep,
                        output logic [15:0] g, output logic [7:0] ot,
                        output logic [7:0] cy, output int lat);
    int n = 0;
    @(negedge clk);
    while (rdy[s] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("ready_timeout", 0, 1);
    drive(s, a, b, t);
    v[s] = 1'b1;
    @(posedge clk);
    #1;
    if (!keep) v[s] = 1'b0;
    drive(s, 16'($urandom), 16'($urandom), 8'($urandom));
    lat = 0;
    while (ov[s] !== 1'b1 && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
      if (keep) drive(s, 16'($urandom), 16'($urandom), 8'($urandom));
    end
    if (lat >= 300) chk("valid_timeout", 0, 1);
    v[s] = 1'b0;
    g  = gx[s];
    ot = tx[s];
    cy = cx[s];
  endtask

  typedef struct {
    int          s;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  t;
    logic [15:0] g;
    logic [7:0]  cy;
    int          lat;
  } vec_t;

  vec_t tv[11];

  initial begin
    logic [15:0] g, ra, rb;
    logic [7:0]  ot, cy, rt;
    int          lat, cnt_v;

    tv[0]  = '{0, 16'd12,    16'd18,   8'd3,    16'd6,    8'd6,  7};
    tv[1]  = '{0, 16'd7,     16'd7,    8'd5,    16'd7,    8'd2,  3};
    tv[2]  = '{0, 16'd0,     16'd9,    8'd6,    16'd9,    8'd0,  1};
    tv[3]  = '{0, 16'd0,     16'd0,    8'd1,    16'd0,    8'd0,  1};
    tv[4]  = '{0, 16'd48,    16'd36,   8'd2,    16'd12,   8'd8,  9};
    tv[5]  = '{0, 16'd9,     16'd0,    8'd15,   16'd9,    8'd0,  1};
    tv[6]  = '{0, 16'd128,   16'd64,   8'd10,   16'd64,   8'd9,  10};
    tv[7]  = '{1, 16'd65535, 16'd255,  8'hA5,   16'd255,  8'd11, 12};
    tv[8]  = '{1, 16'd1024,  16'd4096, 8'h3C,   16'd1024, 8'd14, 15};
    tv[9]  = '{2, 16'd12,    16'd18,   8'd1,    16'd6,    8'd6,  7};
    tv[10] = '{2, 16'd48,    16'd36,   8'd2,    16'd12,   8'd7,  9};

    rst = 1'b1;
    v   = '0;
    dr  = '1;
    for (int s = 0; s < 3; s++) drive(s, 16'd0, 16'd0, 8'd0);
    #12;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("rst_ready%0d", s), 32'(rdy[s]), 1);
      chk($sformatf("rst_valid%0d", s), 32'(ov[s]), 0);
      chk($sformatf("rst_gcd%0d", s), 32'(gx[s]), 0);
      chk($sformatf("rst_tag%0d", s), 32'(tx[s]), 0);
      chk($sformatf("rst_cycles%0d", s), 32'(cx[s]), 0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_op(tv[i].s, tv[i].a, tv[i].b, tv[i].t, 1'b0, g, ot, cy, lat);
      chk($sformatf("tv%0d_gcd", i), 32'(g), 32'(tv[i].g));
      chk($sformatf("tv%0d_tag", i), 32'(ot), 32'(tv[i].t));
      chk($sformatf("tv%0d_cycles", i), 32'(cy), 32'(tv[i].cy));
      chk($sformatf("tv%0d_latency", i), 32'(lat), 32'(tv[i].lat));
      @(posedge clk);
      #1;
      chk($sformatf("tv%0d_valid_one_cycle", i), 32'(ov[tv[i].s]), 0);
      chk($sformatf("tv%0d_ready_after", i), 32'(rdy[tv[i].s]), 1);
    end

    // i_valid held high with changing operands while busy must be ignored.
    run_op(1, 16'd65535, 16'd255, 8'h77, 1'b1, g, ot, cy, lat);
    chk("keep_gcd", 32'(g), 255);
    chk("keep_tag", 32'(ot), 32'h77);
    chk("keep_cycles", 32'(cy), 11);
    repeat (3) @(posedge clk);
    #1;
    chk("keep_no_extra_valid", 32'(ov[1]), 0);
    chk("keep_idle_ready", 32'(rdy[1]), 1);

    // Backpressure: result held for five cycles with i_ready low.
    dr[0] = 1'b0;
    run_op(0, 16'd255, 16'd85, 8'd9, 1'b0, g, ot, cy, lat);
    chk("bp_gcd", 32'(g), 85);
    chk("bp_cycles", 32'(cy), 4);
    chk("bp_latency", 32'(lat), 5);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_hold_valid%0d", i), 32'(ov[0]), 1);
      chk($sformatf("bp_hold_gcd%0d", i), 32'(gx[0]), 85);
      chk($sformatf("bp_hold_tag%0d", i), 32'(tx[0]), 9);
      chk($sformatf("bp_hold_ready%0d", i), 32'(rdy[0]), 0);
    end
    @(negedge clk);
    dr[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_handshake_valid", 32'(ov[0]), 0);
    chk("bp_handshake_ready", 32'(rdy[0]), 1);
    chk("bp_gcd_retained", 32'(gx[0]), 85);

    // Reset in the middle of ITER abandons the operation.
    @(negedge clk);
    drive(0, 16'd200, 16'd150, 8'd7);
    v[0] = 1'b1;
    @(posedge clk);
    #1;
    v[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(ov[0]), 0);
    chk("midrst_ready", 32'(rdy[0]), 1);
    chk("midrst_gcd", 32'(gx[0]), 0);
    chk("midrst_tag", 32'(tx[0]), 0);
    chk("midrst_cycles", 32'(cx[0]), 0);
    @(negedge clk);
    rst   = 1'b0;
    cnt_v = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (ov[0] === 1'b1) cnt_v++;
    end
    chk("midrst_no_result", 32'(cnt_v), 0);
    run_op(0, 16'd48, 16'd36, 8'd4, 1'b0, g, ot, cy, lat);
    chk("postrst_gcd", 32'(g), 12);
    chk("postrst_tag", 32'(ot), 4);
    chk("postrst_cycles", 32'(cy), 8);

    // Random operands against a Euclid reference.
    for (int i = 0; i < 260; i++) begin
      int s;
      s  = (i < 200) ? 1 : 0;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rt = 8'($urandom);
      if (s == 0) begin
        ra = {8'h00, ra[7:0]};
        rb = {8'h00, rb[7:0]};
        rt = {4'h0, rt[3:0]};
      end
      if ($urandom_range(0, 15) == 0) ra = '0;
      if ($urandom_range(0, 15) == 0) rb = '0;
      run_op(s, ra, rb, rt, 1'b0, g, ot, cy, lat);
      chk($sformatf("rnd%0d_gcd(%0d,%0d)", i, ra, rb), 32'(g), 32'(ref_gcd(ra, rb)));
      chk($sformatf("rnd%0d_tag", i), 32'(ot), 32'(rt));
      if (ra == 0 || rb == 0) begin
        chk($sformatf("rnd%0d_zero_cycles", i), 32'(cy), 0);
        chk($sformatf("rnd%0d_zero_latency", i), 32'(lat), 1);
      end else begin
        chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(cy) + 1);
      end
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gcd_stein_unit.md
Name: gcd_stein_unit

Overview:
- Parametrised successor to the 8-bit GCD calculator.
- Computes GCD(a,b) of two WIDTH-bit unsigned operands with the binary (Stein) algorithm, one shift or subtract step per cycle.
- Carries a user tag through with each request and reports the iteration count alongside the result.
- Sits behind a valid/ready request interface and in front of a valid/ready result interface; one operation in flight at a time.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).
- TAG_W, 4, width of the pass-through request tag (≥1).
- CNT_W, 8, width of the iteration counter; the counter saturates at all-ones.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_a  in  WIDTH  operand a.
- i_b  in  WIDTH  operand b.
- i_tag  in  TAG_W  request tag.
- i_valid  in  1  request valid.
- o_ready  out  1  unit can accept a request.
- o_gcd  out  WIDTH  result.
- o_tag  out  TAG_W  tag of the request that produced o_gcd.
- o_cycles  out  CNT_W  clock edges spent in ALIGN plus ITER for this result.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, o_ready=1, o_valid=0, o_gcd=0, o_tag=0, o_cycles=0, all internal registers cleared.
  - Reset mid-operation abandons the operation.
  - No result is produced for an abandoned operation.
- Internal state:
  - Registers ra and rb (WIDTH bits each).
  - k, the common power of two, clog2(WIDTH+1) bits.
  - cnt (CNT_W bits).
  - FSM states: IDLE, ALIGN, ITER, DONE.
- IDLE:
  - o_ready=1 only in this state.
  - On i_valid && o_ready: latch ra=i_a, rb=i_b, tag=i_tag; clear k and cnt.
  - If i_a==0 or i_b==0, set o_gcd=i_a|i_b, o_cycles=0, and go to DONE. gcd(0,0)=0.
  - Otherwise go to ALIGN.
- ALIGN: each edge cnt++ (saturating).
  - If ra[0]==0 && rb[0]==0: shift ra and rb right by 1 and increment k; stay in ALIGN.
  - Otherwise go to ITER with no datapath change.
- ITER: each edge cnt++ (saturating).
  - If either register is even, shift each even register right by 1. Both may shift on the same edge (cannot occur after ALIGN, but must be legal).
  - Else if ra==rb: o_gcd=ra<<k, o_cycles=cnt+1 (saturating), go to DONE.
  - Else if ra>rb: ra=ra-rb.
  - Else: rb=rb-ra.
  - Subtraction is always non-negative. ra<<k never overflows WIDTH because the result ≤ min(a,b).
- DONE:
  - o_valid=1; o_gcd, o_tag and o_cycles are held stable while i_ready=0.
  - On o_valid && i_ready: o_valid=0 and go to IDLE.
  - No new request is accepted in the cycle of the result handshake; o_ready rises the following cycle.
- Latency, acceptance edge to o_valid high:
  - 1 edge for a zero operand.
  - Otherwise 1 + o_cycles edges.
- i_valid is ignored outside IDLE. Inputs need not be held after acceptance.
- Result outputs keep their last values after the handshake until the next result is written.

Test Plan:
- Default params, a=12, b=18, tag=3, i_ready=1 → o_gcd=6, o_tag=3, o_cycles=6, o_valid high 7 edges after the acceptance edge, for exactly 1 cycle.
- a=7, b=7 → o_gcd=7, o_cycles=2. Then a=0, b=9 → o_gcd=9, o_cycles=0, o_valid 1 edge after acceptance. Then a=0, b=0 → o_gcd=0.
- Backpressure: a=255, b=85, i_ready=0 for 5 cycles after o_valid rises → o_valid, o_gcd=85 and o_tag are stable throughout; o_ready=0 throughout; single handshake when i_ready=1; o_ready=1 on the next cycle.
- Reset mid-operation: rst pulsed during ITER of a=200, b=150 → all outputs return to reset values immediately; no o_valid appears; next request a=48, b=36 → 12.
- WIDTH=16, TAG_W=8: a=65535, b=255 → 255; a=1024, b=4096 → 1024; i_valid held high with changing i_a outside IDLE → ignored; 200 random pairs checked against a software GCD model.
